// File: rtl/pixel_fb_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : pixel_fb_writer_pkg                                        |
// | Description : Shared display constants, FSM state encoding and the       |
// |               framebuffer address helper for the pixel writer.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pixel_fb_writer_pkg;

  localparam int X_PIXELS  = 160;
  localparam int Y_PIXELS  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;
  // One FIFO entry carries {address, colour}.
  localparam int FIFO_W    = FB_ADDR_W + COLOUR_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Linear address y*160 + x, built from shifts so no multiplier is needed.
  function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(input logic [6:0] y,
                                                          input logic [7:0] x);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fb_writer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_fifo                                                 |
// | Description : Synchronous FIFO with registered full/empty flags and a    |
// |               look-ahead port exposing the entry behind the head.        |
// | Ports       : clk, reset (sync, active-low), push_i/wdata_i, pop_i,      |
// |               head_o, next_o, full_o, empty_o, count_o                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pixel_fifo
  import pixel_fb_writer_pkg::*;
#(
  parameter int DEPTH = 8,       // power of two
  parameter int WIDTH = FIFO_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    push_ok = push_i && !full_q;
    pop_ok  = pop_i && !empty_q;
    rd_next = rd_ptr_q + AW'(1);
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_next;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_next];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_fb_writer                                            |
// | Description : Buffers plotted pixels, writes them to a framebuffer and   |
// |               performs full-screen clears on request.                    |
// | Ports       : clk, reset (sync, active-low)                              |
// |               pixel in : plot_en, px_x, px_y, px_colour -> px_ready       |
// |               clear    : clear_req, clear_colour -> clear_done          |
// |               fb out   : fb_wren, fb_addr, fb_data <- fb_ready           |
// |               status   : drop_count, busy                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pixel_fb_writer
  import pixel_fb_writer_pkg::*;
#(
  parameter int X_PIXELS   = pixel_fb_writer_pkg::X_PIXELS,
  parameter int Y_PIXELS   = pixel_fb_writer_pkg::Y_PIXELS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 plot_en,
  input  logic [7:0]           px_x,
  input  logic [6:0]           px_y,
  input  logic [COLOUR_W-1:0]  px_colour,
  output logic                 px_ready,
  input  logic                 clear_req,
  input  logic [COLOUR_W-1:0]  clear_colour,
  output logic                 clear_done,
  input  logic                 fb_ready,
  output logic                 fb_wren,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOUR_W-1:0]  fb_data,
  output logic [7:0]           drop_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(X_PIXELS * Y_PIXELS - 1);
  localparam logic [FB_ADDR_W-1:0] CLR_END  = FB_ADDR_W'(X_PIXELS * Y_PIXELS);
  localparam logic [7:0]           X_LIM    = 8'(X_PIXELS);
  localparam logic [6:0]           Y_LIM    = 7'(Y_PIXELS);

  state_t               state_q, state_d;
  logic                 rdy_en_q;
  logic [COLOUR_W-1:0]  colour_q, colour_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                 wren_q, wren_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [COLOUR_W-1:0]  data_q, data_d;
  logic [7:0]           drop_q, drop_d;

  logic                 accept;
  logic                 in_range;
  logic                 fire;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [FIFO_W-1:0]    fifo_wdata;
  logic [FIFO_W-1:0]    fifo_head;
  logic [FIFO_W-1:0]    fifo_next;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // rdy_en_q keeps px_ready low while reset is held, using registered state only.
  assign px_ready   = rdy_en_q && !fifo_full && (state_q == ST_IDLE || state_q == ST_WRITE);
  assign clear_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign fb_wren    = wren_q;
  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign drop_count = drop_q;

  always_comb begin
    accept     = plot_en && px_ready;
    in_range   = (px_x < X_LIM) && (px_y < Y_LIM);
    fifo_push  = accept && in_range;
    fifo_wdata = {fb_linear_addr(px_y, px_x), px_colour};
    fire       = wren_q && fb_ready;
  end

  // Output stage. The presented entry stays in the FIFO until its transfer
  // completes, so FIFO occupancy counts it; on completion the look-ahead
  // entry is loaded directly to keep one write per cycle.
  always_comb begin
    fifo_pop  = 1'b0;
    wren_d    = wren_q;
    addr_d    = addr_q;
    data_d    = data_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (!wren_q || fb_ready) begin
        if (clr_cnt_q != CLR_END) begin
          wren_d    = 1'b1;
          addr_d    = clr_cnt_q;
          data_d    = colour_q;
          clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
        end else begin
          wren_d = 1'b0;
        end
      end
    end else begin
      clr_cnt_d = '0;
      if (!wren_q) begin
        if (!fifo_empty) begin
          wren_d           = 1'b1;
          {addr_d, data_d} = fifo_head;
        end
      end else if (fb_ready) begin
        fifo_pop = 1'b1;
        if (fifo_count >= CNT_W'(2)) begin
          {addr_d, data_d} = fifo_next;
        end else begin
          wren_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    drop_d   = drop_q;
    if (accept && !in_range && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
    unique case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (clear_req) begin
          state_d  = ST_DRAIN;
          colour_d = clear_colour;
        end else if (state_q == ST_IDLE && !fifo_empty) begin
          state_d = ST_WRITE;
        end else if (state_q == ST_WRITE && fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (fifo_empty && !wren_q) state_d = ST_CLEAR;
      ST_CLEAR: if (fire && addr_q == CLR_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rdy_en_q  <= 1'b0;
      colour_q  <= '0;
      clr_cnt_q <= '0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      colour_q  <= colour_d;
      clr_cnt_q <= clr_cnt_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pixel_fb_writer                                         |
// | Description : Directed self-checking bench for pixel_fb_writer.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pixel_fb_writer;

  logic        clk = 1'b0;
  logic        reset, plot_en, clear_req, fb_ready;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_colour, clear_colour;
  logic        px_ready, clear_done, fb_wren, busy;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_fb_writer #(.X_PIXELS(160), .Y_PIXELS(120), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .plot_en(plot_en), .px_x(px_x), .px_y(px_y),
    .px_colour(px_colour), .px_ready(px_ready), .clear_req(clear_req),
    .clear_colour(clear_colour), .clear_done(clear_done), .fb_ready(fb_ready),
    .fb_wren(fb_wren), .fb_addr(fb_addr), .fb_data(fb_data),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; plot_en = 1'b0; clear_req = 1'b0; fb_ready = 1'b0;
    px_x = '0; px_y = '0; px_colour = '0; clear_colour = '0;
    repeat (3) tick();
    n_checks++; if (px_ready !== 1'b0) $display("FAIL rst_px_ready: got %0b want 0", px_ready); else n_pass++;
    n_checks++; if (fb_wren !== 1'b0) $display("FAIL rst_fb_wren: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (fb_addr !== 15'd0) $display("FAIL rst_fb_addr: got %0d want 0", fb_addr); else n_pass++;
    n_checks++; if (fb_data !== 3'd0) $display("FAIL rst_fb_data: got %0d want 0", fb_data); else n_pass++;
    n_checks++; if (clear_done !== 1'b0) $display("FAIL rst_clear_done: got %0b want 0", clear_done); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL rst_drop_count: got %0d want 0", drop_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (px_ready !== 1'b1) $display("FAIL rst_release_px_ready: got %0b want 1", px_ready); else n_pass++;
  endtask

  task automatic test_single_pixel();
    fb_ready = 1'b1;
    px_x = 8'd5; px_y = 7'd3; px_colour = 3'b101; plot_en = 1'b1;
    n_checks++; if (px_ready !== 1'b1) $display("FAIL single_px_ready: got %0b want 1", px_ready); else n_pass++;
    tick();
    plot_en = 1'b0;
    n_checks++; if (fb_wren !== 1'b0) $display("FAIL single_n1_wren: got %0b want 0", fb_wren); else n_pass++;
    tick();
    n_checks++; if (fb_wren !== 1'b1) $display("FAIL single_n2_wren: got %0b want 1", fb_wren); else n_pass++;
    n_checks++; if (fb_addr !== 15'd485) $display("FAIL single_addr: got %0d want 485", fb_addr); else n_pass++;
    n_checks++; if (fb_data !== 3'b101) $display("FAIL single_data: got %b want 101", fb_data); else n_pass++;
    tick();
    n_checks++; if (fb_wren !== 1'b0) $display("FAIL single_after_wren: got %0b want 0", fb_wren); else n_pass++;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_drop();
    int seen = 0;
    fb_ready = 1'b1;
    plot_en = 1'b1; px_x = 8'd160; px_y = 7'd0; px_colour = 3'b111;
    tick();
    if (fb_wren) seen++;
    px_x = 8'd0; px_y = 7'd120;
    tick();
    plot_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fb_wren) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL drop_no_write: got %0d writes want 0", seen); else n_pass++;
    n_checks++; if (drop_count !== 8'd2) $display("FAIL drop_count_2: got %0d want 2", drop_count); else n_pass++;
    plot_en = 1'b1; px_x = 8'd200; px_y = 7'd100;
    repeat (300) tick();
    plot_en = 1'b0;
    tick();
    n_checks++; if (drop_count !== 8'd255) $display("FAIL drop_saturate: got %0d want 255", drop_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc = 0, nw = 0, err = 0;
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      px_x = 8'(10 + i); px_y = 7'd2; px_colour = 3'(i); plot_en = 1'b1;
      if (px_ready) acc++;
      tick();
    end
    plot_en = 1'b0;
    n_checks++; if (acc !== 8) $display("FAIL bp_accepted: got %0d want 8", acc); else n_pass++;
    n_checks++; if (px_ready !== 1'b0) $display("FAIL bp_full_ready: got %0b want 0", px_ready); else n_pass++;
    n_checks++; if (fb_wren !== 1'b1 || fb_addr !== 15'd330) $display("FAIL bp_head: got wren=%0b addr=%0d want 1/330", fb_wren, fb_addr); else n_pass++;
    fb_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (fb_wren) begin
        if (fb_addr !== 15'(330 + nw) || fb_data !== 3'(nw)) err++;
        nw++;
      end
      tick();
    end
    n_checks++; if (nw !== 8) $display("FAIL bp_write_count: got %0d want 8", nw); else n_pass++;
    n_checks++; if (err !== 0) $display("FAIL bp_order: got %0d bad writes want 0", err); else n_pass++;
    n_checks++; if (px_ready !== 1'b1) $display("FAIL bp_ready_back: got %0b want 1", px_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int err = 0, acc = 0;
    fb_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c <= 5) begin
        if (fb_wren !== 1'b1 || fb_addr !== 15'(20 + c - 2)) err++;
      end else if (fb_wren !== 1'b0) begin
        err++;
      end
      plot_en = (c < 4); px_x = 8'(20 + c); px_y = 7'd0; px_colour = 3'b011;
      if (plot_en && px_ready) acc++;
      tick();
    end
    plot_en = 1'b0;
    n_checks++; if (acc !== 4) $display("FAIL b2b_accepted: got %0d want 4", acc); else n_pass++;
    n_checks++; if (err !== 0) $display("FAIL b2b_stream: got %0d bad cycles want 0", err); else n_pass++;
  endtask

  task automatic test_toggle();
    int nw = 0, order_err = 0, hold_err = 0;
    logic        pw = 1'b0, pr = 1'b0;
    logic [14:0] pa = '0;
    logic [2:0]  pd = '0;
    for (int c = 0; c < 40; c++) begin
      plot_en = (c < 4); px_x = 8'(40 + c); px_y = 7'd1; px_colour = 3'(c + 1);
      fb_ready = c[0];
      if (fb_wren && pw && !pr && (fb_addr !== pa || fb_data !== pd)) hold_err++;
      if (fb_wren && fb_ready) begin
        if (fb_addr !== 15'(200 + nw) || fb_data !== 3'(nw + 1)) order_err++;
        nw++;
      end
      pw = fb_wren; pr = fb_ready; pa = fb_addr; pd = fb_data;
      tick();
    end
    plot_en = 1'b0; fb_ready = 1'b1;
    n_checks++; if (nw !== 4) $display("FAIL tog_write_count: got %0d want 4", nw); else n_pass++;
    n_checks++; if (order_err !== 0) $display("FAIL tog_order: got %0d bad writes want 0", order_err); else n_pass++;
    n_checks++; if (hold_err !== 0) $display("FAIL tog_hold: got %0d changes while stalled want 0", hold_err); else n_pass++;
  endtask

  task automatic test_clear();
    int nw = 0, err = 0, pulses = 0, post = 0;
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      plot_en = 1'b1; px_x = 8'(1 + i); px_y = 7'd0; px_colour = 3'(4 + i);
      tick();
    end
    plot_en = 1'b0; clear_req = 1'b1; clear_colour = 3'b010;
    tick();
    clear_req = 1'b0; clear_colour = 3'b111;
    n_checks++; if (px_ready !== 1'b0) $display("FAIL clr_ready_low: got %0b want 0", px_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL clr_busy: got %0b want 1", busy); else n_pass++;
    fb_ready = 1'b1;
    for (int c = 0; c < 19400 && post < 5; c++) begin
      if (fb_wren) begin
        if (nw < 3) begin
          if (fb_addr !== 15'(nw + 1) || fb_data !== 3'(4 + nw)) err++;
        end else if (fb_addr !== 15'(nw - 3) || fb_data !== 3'b010) begin
          err++;
        end
        nw++;
      end
      if (clear_done) pulses++;
      if (pulses > 0) post++;
      tick();
    end
    n_checks++; if (nw !== 19203) $display("FAIL clr_write_count: got %0d want 19203", nw); else n_pass++;
    n_checks++; if (err !== 0) $display("FAIL clr_sequence: got %0d bad writes want 0", err); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL clr_done_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clr_end_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (px_ready !== 1'b1) $display("FAIL clr_end_ready: got %0b want 1", px_ready); else n_pass++;
  endtask

  task automatic test_abort();
    int found = 0, bad = 0;
    fb_ready = 1'b1; clear_req = 1'b1; clear_colour = 3'b110;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 6000 && found == 0; c++) begin
      if (fb_wren && fb_addr == 15'd5000) found = 1;
      else tick();
    end
    n_checks++; if (found !== 1) $display("FAIL abort_reach_5000: got found=%0d want 1", found); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (fb_wren !== 1'b0) $display("FAIL abort_wren: got %0b want 0", fb_wren); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (px_ready !== 1'b0) $display("FAIL abort_ready_in_reset: got %0b want 0", px_ready); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL abort_drop_clr: got %0d want 0", drop_count); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (px_ready !== 1'b1) $display("FAIL abort_ready_back: got %0b want 1", px_ready); else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (clear_done || fb_wren) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_drop();
    test_backpressure();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_toggle();
    repeat (3) tick();
    test_clear();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
